branch_pred_unit: RTL



---
 rtl/branch_pred_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB branch predictor: combinational IF-stage lookup, EX-stage
// training with per-entry saturating counters and a saturating mispredict counter.
module branch_pred_unit #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      lk_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_next,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispred,
  input  logic             inv,
  output logic [CNT_W-1:0] mp_cnt
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == {CTR_W{1'b1}}) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CNT_W-1:0]   mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;

  logic             wr_en;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      tgt_d;
  logic [CTR_W-1:0] ctr_d;

  // Only the index/tag slices of the PCs feed logic; the remaining bits are don't-care.
  logic unused_pc;
  assign unused_pc = ^{lk_pc, upd_pc};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_next  = pred_taken ? tgt_q[lk_idx] : lk_pc + 32'd4;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mp_cnt  = mp_cnt_q;

  always_comb begin
    wr_en   = 1'b0;
    valid_d = valid_q[upd_idx];
    tag_d   = tag_q[upd_idx];
    tgt_d   = tgt_q[upd_idx];
    ctr_d   = ctr_q[upd_idx];
    if (upd_valid && !inv) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          ctr_d = ctr_inc(ctr_q[upd_idx]);
          tgt_d = upd_target;
        end else begin
          ctr_d = ctr_dec(ctr_q[upd_idx]);
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever alias currently occupies the slot.
        wr_en   = 1'b1;
        valid_d = 1'b1;
        tag_d   = upd_tag;
        tgt_d   = upd_target;
        ctr_d   = CTR_WT;
      end
    end
  end

  assign mp_cnt_d = (upd_valid && upd_mispred) ? cnt_inc(mp_cnt_q) : mp_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      mp_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      mp_cnt_q <= mp_cnt_d;
      if (inv) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[upd_idx] <= valid_d;
        tag_q[upd_idx]   <= tag_d;
        tgt_q[upd_idx]   <= tgt_d;
        ctr_q[upd_idx]   <= ctr_d;
      end
    end
  end

endmodule
